// File: rtl/one_hot_grant_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : one_hot_grant_decoder
//  Description : Receiving end of the priority-encoder interface. Accepts an
//                encoded index while idle and turns it into a registered
//                one-hot grant. The grant is held until the requester
//                acknowledges it (honoured only after a minimum hold time)
//                or until a timeout forces it off.
//  Ports       :
//    Clock_In          in   1             rising-edge clock
//    Reset_In          in   1             asynchronous active-high reset
//    Valid_In          in   1             Encoded_Value_In is valid
//    Encoded_Value_In  in   SEL_WIDTH     index to grant
//    Ready_Out         out  1             idle, a request can be accepted
//    Ack_In            in   1             requester releases current grant
//    Grant_Out         out  2**SEL_WIDTH  registered one-hot grant
//    Grant_Valid_Out   out  1             registered, equals |Grant_Out
//    Timeout_Out       out  1             one-cycle pulse on forced release
//  Revision    : 1.0 - initial release
// ============================================================================
module one_hot_grant_decoder #(
  parameter int SEL_WIDTH      = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  input  logic                      Valid_In,
  input  logic [SEL_WIDTH-1:0]      Encoded_Value_In,
  output logic                      Ready_Out,
  input  logic                      Ack_In,
  output logic [(1<<SEL_WIDTH)-1:0] Grant_Out,
  output logic                      Grant_Valid_Out,
  output logic                      Timeout_Out
);

  localparam int GRANT_WIDTH = 1 << SEL_WIDTH;
  localparam int CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0]   c_cnt_one     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   c_hold        = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   c_timeout     = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [GRANT_WIDTH-1:0] c_grant_one   = GRANT_WIDTH'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [GRANT_WIDTH-1:0] r_grant;
  logic                   r_grant_valid;
  logic                   r_ready;
  logic                   r_timeout;

  logic [GRANT_WIDTH-1:0] w_decoded;
  logic                   w_accept;
  logic                   w_ack_ok;
  logic                   w_expired;

  // The decoded index is only consumed on the accepting edge, so an
  // undefined index while Valid_In is low never reaches a register.
  assign w_decoded = c_grant_one << Encoded_Value_In;
  assign w_accept  = Valid_In && r_ready;

  // r_count is the 1-based number of the current grant cycle, so an ack is
  // honoured only once the grant has been visible for HOLD_CYCLES cycles.
  // An early ack is simply dropped; nothing remembers it.
  assign w_ack_ok  = Ack_In && (r_count >= c_hold);
  assign w_expired = (r_count == c_timeout);

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ready       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= 1'b0;
          if (w_accept) begin
            r_grant       <= w_decoded;
            r_grant_valid <= 1'b1;
            r_ready       <= 1'b0;
            r_count       <= c_cnt_one;
            r_state       <= ST_GRANT;
          end else begin
            // Covers the first edge after reset release, where Ready_Out
            // is still low and Valid_In must not be taken.
            r_ready <= 1'b1;
          end
        end

        ST_GRANT: begin
          if (w_ack_ok) begin
            // Ack has priority over a coincident timeout.
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_count       <= '0;
            r_state       <= ST_RELEASE;
          end else if (w_expired) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b1;
            r_count       <= '0;
            r_state       <= ST_RELEASE;
          end else if (r_count != c_timeout) begin
            r_count <= r_count + c_cnt_one;
          end
        end

        ST_RELEASE: begin
          r_timeout <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          r_state       <= ST_IDLE;
          r_count       <= '0;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_ready       <= 1'b0;
          r_timeout     <= 1'b0;
        end
      endcase
    end
  end

  assign Grant_Out       = r_grant;
  assign Grant_Valid_Out = r_grant_valid;
  assign Ready_Out       = r_ready;
  assign Timeout_Out     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_one_hot_grant_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_hot_grant_decoder
//  Description : Self-checking bench for one_hot_grant_decoder. Directed
//                table of transactions, reset corner cases, and a random
//                sweep predicted by a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_one_hot_grant_decoder;

  localparam int SEL_WIDTH      = 2;
  localparam int HOLD_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int GW             = 1 << SEL_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic [SEL_WIDTH-1:0] enc_in = '0;
  logic                 ack_in = 1'b0;
  logic                 ready_out;
  logic [GW-1:0]        grant_out;
  logic                 grant_valid_out;
  logic                 timeout_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  one_hot_grant_decoder #(
    .SEL_WIDTH      (SEL_WIDTH),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dut (
    .Clock_In         (clk),
    .Reset_In         (rst),
    .Valid_In         (valid_in),
    .Encoded_Value_In (enc_in),
    .Ready_Out        (ready_out),
    .Ack_In           (ack_in),
    .Grant_Out        (grant_out),
    .Grant_Valid_Out  (grant_valid_out),
    .Timeout_Out      (timeout_out)
  );

  typedef struct {
    string                name;
    logic [SEL_WIDTH-1:0] idx;
    logic [15:0]          ack_mask;   // bit k: Ack_In high in grant cycle k
    int                   exp_len;
    bit                   exp_to;
    bit                   hold_valid; // keep Valid_In high with changing index
  } txn_t;

  txn_t table_v[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [GW-1:0] g,
                       input logic gv, input logic rdy, input logic to);
    logic [GW+2:0] act;
    logic [GW+2:0] req;
    act = {grant_out, grant_valid_out, ready_out, timeout_out};
    req = {g, gv, rdy, to};
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: grant,valid,ready,timeout got %b required %b", name, act, req);
    end
  endtask

  // Transaction-level prediction: the grant lasts until the first ack that
  // falls in a cycle >= HOLD_CYCLES, otherwise the full TIMEOUT_CYCLES with
  // a timeout pulse.
  function automatic int model_len(input logic [15:0] m);
    for (int k = HOLD_CYCLES; k <= TIMEOUT_CYCLES; k++)
      if (m[k]) return k;
    return TIMEOUT_CYCLES;
  endfunction

  function automatic bit model_to(input logic [15:0] m);
    for (int k = HOLD_CYCLES; k <= TIMEOUT_CYCLES; k++)
      if (m[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Entered in an IDLE cycle with Ready_Out=1; leaves in the IDLE cycle that
  // follows the release cycle.
  task automatic run_txn(input string name, input logic [SEL_WIDTH-1:0] idx,
                         input logic [15:0] mask, input int exp_len,
                         input bit exp_to, input bit hold_valid);
    logic [GW-1:0] exp_g;
    exp_g      = '0;
    exp_g[idx] = 1'b1;
    valid_in = 1'b1;
    enc_in   = idx;
    ack_in   = 1'b0;
    tick;
    for (int k = 1; k <= exp_len; k++) begin
      check($sformatf("%s grant_c%0d", name, k), exp_g, 1'b1, 1'b0, 1'b0);
      ack_in   = mask[k];
      valid_in = hold_valid;
      enc_in   = SEL_WIDTH'(k % GW);
      tick;
    end
    check({name, " release"}, '0, 1'b0, 1'b0, exp_to);
    ack_in = hold_valid;
    tick;
    check({name, " idle"}, '0, 1'b0, 1'b1, 1'b0);
    ack_in   = 1'b0;
    valid_in = 1'b0;
  endtask

  initial begin
    logic [15:0]          mask;
    logic [SEL_WIDTH-1:0] ridx;
    int                   gap;
    int                   mode;

    table_v[0] = '{"ack_c4",        2'd2, 16'h0010, 4,  1'b0, 1'b0};
    table_v[1] = '{"early_acks",    2'd1, 16'h000E, 15, 1'b1, 1'b0};
    table_v[2] = '{"ack_c15",       2'd3, 16'h8000, 15, 1'b0, 1'b0};
    table_v[3] = '{"ack_c3_c7",     2'd0, 16'h0088, 7,  1'b0, 1'b0};
    table_v[4] = '{"no_ack_valid",  2'd0, 16'h0000, 15, 1'b1, 1'b1};
    table_v[5] = '{"next_after_hv", 2'd3, 16'h0020, 5,  1'b0, 1'b1};
    table_v[6] = '{"ack_c14",       2'd1, 16'h4000, 14, 1'b0, 1'b0};
    table_v[7] = '{"ack_c4_hold",   2'd2, 16'hFFFF, 4,  1'b0, 1'b0};

    // Reset state, then reset release with Valid_In already high: the first
    // edge only raises Ready_Out, nothing is granted.
    tick;
    check("reset_state", '0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b0;
    valid_in = 1'b1;
    enc_in   = 2'd3;
    check("after_release_no_edge", '0, 1'b0, 1'b0, 1'b0);
    tick;
    check("first_edge_ready", '0, 1'b0, 1'b1, 1'b0);
    valid_in = 1'b0;

    // Directed table.
    foreach (table_v[i])
      run_txn(table_v[i].name, table_v[i].idx, table_v[i].ack_mask,
              table_v[i].exp_len, table_v[i].exp_to, table_v[i].hold_valid);

    // Reset in the middle of a grant clears everything without a clock.
    valid_in = 1'b1;
    enc_in   = 2'd1;
    tick;
    check("pre_reset_grant", 4'b0010, 1'b1, 1'b0, 1'b0);
    valid_in = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("async_reset_clear", '0, 1'b0, 1'b0, 1'b0);
    tick;
    check("reset_held", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    check("ready_after_reset", '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TIMEOUT_CYCLES + 2; k++) begin
      tick;
      check("no_timeout_after_reset", '0, 1'b0, 1'b1, 1'b0);
    end

    // Random sweep against the transaction model.
    for (int r = 0; r < 500; r++) begin
      ridx = SEL_WIDTH'($urandom_range(0, GW - 1));
      mode = $urandom_range(0, 2);
      case (mode)
        0:       mask = 16'($urandom) & 16'($urandom) & 16'hFFFE;
        1:       mask = 16'($urandom) & 16'h000E;
        default: mask = 16'h0001 << $urandom_range(1, 15);
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ack_in = 1'($urandom);
        enc_in = SEL_WIDTH'($urandom);
        tick;
        check("rand_idle_gap", '0, 1'b0, 1'b1, 1'b0);
      end
      run_txn($sformatf("rand%0d", r), ridx, mask, model_len(mask),
              model_to(mask), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
